// File: rtl/cust_afu_sq_doorbell_arb_if.sv
// Doorbell stream from the SQ doorbell arbiter to the NVMe submit engine.
// The arbiter drives the master side. The submit engine drives the slave side.
interface cust_afu_sq_doorbell_arb_if #(
   parameter int unsigned CH_W   = 3,
   parameter int unsigned TAIL_W = 6
);
   logic              db_valid;
   logic              db_ready;
   logic [CH_W-1:0]   db_ch;
   logic [TAIL_W-1:0] db_tail;
   logic [TAIL_W-1:0] db_count;

   modport master (output db_valid, db_ch, db_tail, db_count, input db_ready);
   modport slave  (input db_valid, db_ch, db_tail, db_count, output db_ready);
endinterface

// File: rtl/cust_afu_sq_doorbell_arb.sv
// SQ tail change detector, coalescer and round-robin doorbell arbiter (axi4_mm_clk domain).
// Define SQ_DB_STATS_EN to add the per-channel issued-doorbell counters on db_issued_cnt.
module cust_afu_sq_doorbell_arb #(
   parameter int unsigned BE_CH       = 8,
   parameter int unsigned QUEUE_DEPTH = 64
) (
   input  logic                   axi4_mm_clk,
   input  logic                   axi4_mm_rst_n,
   input  logic [BE_CH-1:0][63:0] sq_tail_avmm,
   input  logic                   nvme_end_proc_avmm,
   cust_afu_sq_doorbell_arb_if.master db,
   output logic [BE_CH-1:0]       err_mask
`ifdef SQ_DB_STATS_EN
   ,
   output logic [BE_CH-1:0][31:0] db_issued_cnt
`endif
);
   localparam int unsigned TAIL_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CH_W   = (BE_CH > 1) ? $clog2(BE_CH) : 1;

   logic [BE_CH-1:0][TAIL_W-1:0] tail_lo_c;
   logic [BE_CH-1:0][TAIL_W-1:0] prev_q;
   logic [BE_CH-1:0][TAIL_W-1:0] last_q, last_d;
   logic [BE_CH-1:0][TAIL_W-1:0] pend_q, pend_d;
   logic [BE_CH-1:0]             pending_q, pending_d;
   logic [BE_CH-1:0]             err_q, err_d;
   logic [CH_W-1:0]              rr_q, rr_d;
   logic                         valid_q, valid_d;
   logic [CH_W-1:0]              ch_q, ch_d;
   logic [TAIL_W-1:0]            tail_q, tail_d;
   logic [TAIL_W-1:0]            count_q, count_d;
   logic                         gnt_vld_c;
   logic [CH_W-1:0]              gnt_ch_c;
   logic                         load_c;

   always_comb begin
      for (int ch = 0; ch < int'(BE_CH); ch++) begin
         tail_lo_c[ch] = sq_tail_avmm[ch][TAIL_W-1:0];
      end
   end

   // Scan downward from the farthest offset so the nearest pending channel at/after rr_q wins.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_vld_c = 1'b0;
      gnt_ch_c  = '0;
      for (int i = int'(BE_CH) - 1; i >= 0; i--) begin
         idx = 32'(rr_q) + 32'(i);
         if (idx >= BE_CH) idx = idx - BE_CH;
         if (pending_q[idx]) begin
            gnt_vld_c = 1'b1;
            gnt_ch_c  = CH_W'(idx);
         end
      end
   end

   assign load_c = !valid_q || db.db_ready;

   always_comb begin
      logic [TAIL_W-1:0] ref_t;
      logic [TAIL_W:0]   diff;
      valid_d   = valid_q;
      ch_d      = ch_q;
      tail_d    = tail_q;
      count_d   = count_q;
      rr_d      = rr_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      last_d    = last_q;
      err_d     = err_q;
      ref_t     = '0;
      diff      = '0;

      if (load_c) begin
         if (gnt_vld_c) begin
            if (pend_q[gnt_ch_c] >= last_q[gnt_ch_c])
               diff = {1'b0, pend_q[gnt_ch_c]} - {1'b0, last_q[gnt_ch_c]};
            else
               diff = {1'b0, pend_q[gnt_ch_c]} + (TAIL_W+1)'(QUEUE_DEPTH) - {1'b0, last_q[gnt_ch_c]};
            valid_d             = 1'b1;
            ch_d                = gnt_ch_c;
            tail_d              = pend_q[gnt_ch_c];
            count_d             = TAIL_W'(diff);
            pending_d[gnt_ch_c] = 1'b0;
            last_d[gnt_ch_c]    = pend_q[gnt_ch_c];
            rr_d = (gnt_ch_c == CH_W'(BE_CH - 1)) ? '0 : gnt_ch_c + CH_W'(1);
         end else if (db.db_ready) begin
            valid_d = 1'b0;
         end
      end

      // Accept runs after the grant so a same-edge accept re-arms the channel with the newer tail.
      for (int ch = 0; ch < int'(BE_CH); ch++) begin
         ref_t = pending_q[ch] ? pend_q[ch] : last_q[ch];
         if (!nvme_end_proc_avmm && (tail_lo_c[ch] == prev_q[ch])) begin
            if (sq_tail_avmm[ch] >= 64'(QUEUE_DEPTH)) begin
               err_d[ch] = 1'b1;
            end else if (tail_lo_c[ch] != ref_t) begin
               pending_d[ch] = 1'b1;
               pend_d[ch]    = tail_lo_c[ch];
            end
         end
      end

      if (nvme_end_proc_avmm) begin
         pending_d = '0;
         err_d     = '0;
         last_d    = '0;
         valid_d   = 1'b0;
         rr_d      = '0;
      end
   end

   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         prev_q    <= '0;
         last_q    <= '0;
         pend_q    <= '0;
         pending_q <= '0;
         err_q     <= '0;
         rr_q      <= '0;
         valid_q   <= 1'b0;
         ch_q      <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         prev_q    <= tail_lo_c;
         last_q    <= last_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         rr_q      <= rr_d;
         valid_q   <= valid_d;
         ch_q      <= ch_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   assign db.db_valid = valid_q;
   assign db.db_ch    = ch_q;
   assign db.db_tail  = tail_q;
   assign db.db_count = count_q;
   assign err_mask    = err_q;

`ifdef SQ_DB_STATS_EN
   logic [BE_CH-1:0][31:0] issued_q;

   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         issued_q <= '0;
      end else if (nvme_end_proc_avmm) begin
         issued_q <= '0;
      end else if (valid_q && db.db_ready) begin
         issued_q[ch_q] <= issued_q[ch_q] + 32'd1;
      end
   end

   assign db_issued_cnt = issued_q;
`endif
endmodule

// File: tb/tb_cust_afu_sq_doorbell_arb.sv
// Directed bench for the SQ doorbell arbiter: latency, wrap, coalescing, round-robin,
// range errors, flush and reset behaviour (counters too when SQ_DB_STATS_EN is defined).
module tb_cust_afu_sq_doorbell_arb;
   localparam int unsigned BE_CH       = 8;
   localparam int unsigned QUEUE_DEPTH = 64;

   typedef struct {
      int ch;
      int tail;
      int cnt;
   } beat_t;

   logic                   clk;
   logic                   rst_n;
   logic [BE_CH-1:0][63:0] sq_tail;
   logic                   flush;
   logic [BE_CH-1:0]       err_mask;
`ifdef SQ_DB_STATS_EN
   logic [BE_CH-1:0][31:0] issued;
`endif

   int    n_chk  = 0;
   int    n_pass = 0;
   beat_t beats[$];

   cust_afu_sq_doorbell_arb_if #(.CH_W(3), .TAIL_W(6)) dbi ();

   cust_afu_sq_doorbell_arb #(.BE_CH(BE_CH), .QUEUE_DEPTH(QUEUE_DEPTH)) dut (
      .axi4_mm_clk        (clk),
      .axi4_mm_rst_n      (rst_n),
      .sq_tail_avmm       (sq_tail),
      .nvme_end_proc_avmm (flush),
      .db                 (dbi),
      .err_mask           (err_mask)
`ifdef SQ_DB_STATS_EN
      ,
      .db_issued_cnt      (issued)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each accepted beat is recorded once, mid-cycle.
   always @(negedge clk) begin
      if (rst_n && dbi.db_valid && dbi.db_ready)
         beats.push_back('{int'(dbi.db_ch), int'(dbi.db_tail), int'(dbi.db_count)});
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_beats(input string tag, input int n);
      for (int k = 0; k < 60 && beats.size() < n; k++) step();
      check({tag, "_nbeats"}, 64'(beats.size()), 64'(n));
   endtask

   task automatic pop_beat(input string tag, input int ch, input int tail, input int cnt);
      beat_t b;
      if (beats.size() == 0) begin
         check({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         b = beats.pop_front();
         check({tag, "_ch"},    64'(b.ch),   64'(ch));
         check({tag, "_tail"},  64'(b.tail), 64'(tail));
         check({tag, "_count"}, 64'(b.cnt),  64'(cnt));
      end
   endtask

   task automatic chk_out(input string tag, input int ch, input int tail, input int cnt);
      check({tag, "_valid"}, 64'(dbi.db_valid), 64'd1);
      check({tag, "_ch"},    64'(dbi.db_ch),    64'(ch));
      check({tag, "_tail"},  64'(dbi.db_tail),  64'(tail));
      check({tag, "_count"}, 64'(dbi.db_count), 64'(cnt));
   endtask

   // Zero all tails under flush so nothing is re-accepted once flush drops.
   task automatic do_flush();
      sq_tail = '0;
      flush   = 1'b1;
      step(2);
      flush = 1'b0;
      step();
      beats.delete();
   endtask

   initial begin
      rst_n         = 1'b0;
      sq_tail       = '0;
      flush         = 1'b0;
      dbi.db_ready  = 1'b0;
      step(2);
      check("rst_valid", 64'(dbi.db_valid), 64'd0);
      check("rst_ch",    64'(dbi.db_ch),    64'd0);
      check("rst_tail",  64'(dbi.db_tail),  64'd0);
      check("rst_count", 64'(dbi.db_count), 64'd0);
      check("rst_err",   64'(err_mask),     64'd0);
      rst_n = 1'b1;
      step(2);

      // Single doorbell, exact latency
      dbi.db_ready = 1'b1;
      sq_tail[2]   = 64'd5;
      step();
      check("lat_e1_valid", 64'(dbi.db_valid), 64'd0);
      step();
      check("lat_e2_valid", 64'(dbi.db_valid), 64'd0);
      step();
      chk_out("single", 2, 5, 5);
      step();
      check("single_drop", 64'(dbi.db_valid), 64'd0);
      step(3);
      check("single_nbeats", 64'(beats.size()), 64'd1);
      beats.delete();

      // Ring wrap on ch0
      sq_tail[0] = 64'd60;
      wait_beats("wrap1", 1);
      pop_beat("wrap1", 0, 60, 60);
      sq_tail[0] = 64'd3;
      wait_beats("wrap2", 1);
      pop_beat("wrap2", 0, 3, 7);

      // Coalesce under backpressure on ch1
      step(2);
      dbi.db_ready = 1'b0;
      sq_tail[1]   = 64'd4;
      step(3);
      chk_out("bp_first", 1, 4, 4);
      sq_tail[1] = 64'd7;
      step(3);
      sq_tail[1] = 64'd9;
      step(4);
      chk_out("bp_hold", 1, 4, 4);
      dbi.db_ready = 1'b1;
      wait_beats("bp", 2);
      pop_beat("bp_a", 1, 4, 4);
      pop_beat("bp_b", 1, 9, 5);
      step(4);
      check("bp_no_extra", 64'(beats.size()), 64'd0);

      // Round-robin from rr_ptr=0
      do_flush();
      sq_tail[0] = 64'd2;
      sq_tail[3] = 64'd3;
      sq_tail[7] = 64'd4;
      step(3);
      chk_out("rr0_a", 0, 2, 2);
      step();
      chk_out("rr0_b", 3, 3, 3);
      step();
      chk_out("rr0_c", 7, 4, 4);
      step();
      check("rr0_drop", 64'(dbi.db_valid), 64'd0);

      // A ch3 doorbell leaves rr_ptr at 4
      sq_tail[3] = 64'd5;
      step(6);
      beats.delete();
      sq_tail[0] = 64'd6;
      sq_tail[3] = 64'd8;
      sq_tail[7] = 64'd9;
      step(3);
      chk_out("rr4_a", 7, 9, 5);
      step();
      chk_out("rr4_b", 0, 6, 4);
      step();
      chk_out("rr4_c", 3, 8, 3);
      step(3);
      beats.delete();

      // Range error on ch5, glitching ch6
      sq_tail[5] = 64'd70;
      for (int i = 0; i < 10; i++) begin
         sq_tail[6] = (i % 2 == 0) ? 64'd2 : 64'd1;
         step();
      end
      sq_tail[6] = 64'd0;
      step(4);
      check("err_mask", 64'(err_mask), 64'h20);
      check("err_nbeats", 64'(beats.size()), 64'd0);

      // Flush clears err_mask and last_tail, and drops a held doorbell
      dbi.db_ready = 1'b0;
      sq_tail[2]   = 64'd9;
      step(4);
      check("fl_held_valid", 64'(dbi.db_valid), 64'd1);
      do_flush();
      check("fl_err",   64'(err_mask),     64'd0);
      check("fl_valid", 64'(dbi.db_valid), 64'd0);
      dbi.db_ready = 1'b1;
      sq_tail[0]   = 64'd10;
      wait_beats("fl_last", 1);
      pop_beat("fl_last", 0, 10, 10);

`ifdef SQ_DB_STATS_EN
      do_flush();
      for (int v = 1; v <= 3; v++) begin
         sq_tail[4] = 64'(v);
         wait_beats("st", 1);
         pop_beat("st", 4, v, 1);
         step(2);
      end
      for (int ch = 0; ch < int'(BE_CH); ch++)
         check("st_cnt", 64'(issued[ch]), (ch == 4) ? 64'd3 : 64'd0);
      do_flush();
      for (int ch = 0; ch < int'(BE_CH); ch++)
         check("st_flush", 64'(issued[ch]), 64'd0);
`endif

      // Async reset drops a held doorbell immediately
      do_flush();
      dbi.db_ready = 1'b0;
      sq_tail[2]   = 64'd7;
      step(4);
      chk_out("ar_held", 2, 7, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(dbi.db_valid), 64'd0);
      sq_tail = '0;
      step(2);
      rst_n = 1'b1;
      step(3);
      check("ar_post_valid", 64'(dbi.db_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
